// File: rtl/stb_dcache_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// stb_dcache_arbiter
//
// Shares a single data-cache port between LSU loads and store-buffer drains.
// A three-state FSM (IDLE / LOAD / STORE) grants one transaction at a time.
// The request payload is captured at grant time and held until the cache acks.
// Loads normally win over drains. A pending drain still gets the port when:
//   - the store buffer is full,
//   - STARVE_MAX loads in a row have been granted while it waited, or
//   - the load targets the same word as the store-buffer head (ordering).
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   lsu_req_i / lsu_addr_i          load request (held until lsu_ack_o)
//   lsu_ack_o / lsu_rdata_o         load completion and data (combinational)
//   stb_req_i / stb_addr_i /
//   stb_wdata_i / stb_sel_i         store-buffer head entry
//   stb_full_i                      store buffer full
//   stb_ack_o                       head entry written; store buffer pops
//   dcache_req_o / dcache_w_en_o    cache request and write enable
//   dcache_addr_o / dcache_wdata_o /
//   dcache_sel_o                    captured request payload
//   dcache_ack_i / dcache_rdata_i   cache completion and read data
// -----------------------------------------------------------------------------
module stb_dcache_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // LSU load port
  input  logic                lsu_req_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  output logic                lsu_ack_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  // Store buffer drain port
  input  logic                stb_req_i,
  input  logic [ADDR_W-1:0]   stb_addr_i,
  input  logic [DATA_W-1:0]   stb_wdata_i,
  input  logic [DATA_W/8-1:0] stb_sel_i,
  input  logic                stb_full_i,
  output logic                stb_ack_o,
  // Data cache port
  output logic                dcache_req_o,
  output logic                dcache_w_en_o,
  output logic [ADDR_W-1:0]   dcache_addr_o,
  output logic [DATA_W-1:0]   dcache_wdata_o,
  output logic [DATA_W/8-1:0] dcache_sel_o,
  input  logic                dcache_ack_i,
  input  logic [DATA_W-1:0]   dcache_rdata_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2
  } state_e;

  state_e             state_q,  state_d;
  logic [ADDR_W-1:0]  addr_q,   addr_d;
  logic [DATA_W-1:0]  wdata_q,  wdata_d;
  logic [SEL_W-1:0]   sel_q,    sel_d;
  logic [CNT_W-1:0]   starve_q, starve_d;

  logic same_word;
  logic starved;
  logic grant_store;

  // Word-granular match: a load must not bypass a pending store to its word.
  assign same_word = (lsu_addr_i[ADDR_W-1:2] == stb_addr_i[ADDR_W-1:2]);
  assign starved   = (starve_q == STARVE_LIM);

  // Collapsed priority: the drain wins whenever it is pending and either a
  // forcing condition holds or there is no competing load.
  assign grant_store = stb_req_i &&
                       (stb_full_i || starved || (lsu_req_i && same_word) || !lsu_req_i);

  // NOTE: every next-state variable gets a hold default first, so no path
  // through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    starve_d = starve_q;

    unique case (state_q)
      S_IDLE: begin
        if (grant_store) begin
          state_d  = S_STORE;
          addr_d   = stb_addr_i;
          wdata_d  = stb_wdata_i;
          sel_d    = stb_sel_i;
          starve_d = '0;
        end else if (lsu_req_i) begin
          state_d = S_LOAD;
          addr_d  = lsu_addr_i;
          wdata_d = '0;
          sel_d   = '1;
          // Only loads that overtake a waiting drain count toward starvation.
          if (stb_req_i && !starved) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end
      end
      S_LOAD, S_STORE: begin
        // Requesters may drop mid-transaction; only the cache ack ends it.
        if (dcache_ack_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments with an asynchronous active-low
  // reset, so every register updates together on the edge and reset takes
  // effect without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      sel_q    <= sel_d;
      starve_q <= starve_d;
    end
  end

  // Cache-side outputs come straight from registers, so they are glitch-free
  // and stable for the whole transaction.
  assign dcache_req_o   = (state_q != S_IDLE);
  assign dcache_w_en_o  = (state_q == S_STORE);
  assign dcache_addr_o  = addr_q;
  assign dcache_wdata_o = wdata_q;
  assign dcache_sel_o   = sel_q;

  // Acks are qualified by state so a stray cache ack in IDLE is swallowed.
  assign lsu_ack_o   = dcache_ack_i && (state_q == S_LOAD);
  assign lsu_rdata_o = lsu_ack_o ? dcache_rdata_i : '0;
  assign stb_ack_o   = dcache_ack_i && (state_q == S_STORE);

endmodule

// File: doc/stb_dcache_arbiter.md
STB_DCACHE_ARBITER -- requirements
Module: stb_dcache_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of every address port.
REQ-002 Parameter DATA_W, default 32, data width; byte-select width SHALL be DATA_W/8.
REQ-003 Parameter STARVE_MAX, default 4, maximum number of consecutive load grants allowed while a store drain is pending.
REQ-004 clk  in  1  clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 lsu_req_i  in  1  load request from the LSU; held high until lsu_ack_o.
REQ-007 lsu_addr_i  in  ADDR_W  load address.
REQ-008 lsu_ack_o  out  1  load complete; lsu_rdata_o valid in the same cycle.
REQ-009 lsu_rdata_o  out  DATA_W  load data.
REQ-010 stb_req_i  in  1  store buffer non-empty; head entry is ready to drain.
REQ-011 stb_addr_i / stb_wdata_i / stb_sel_i  in  ADDR_W / DATA_W / DATA_W/8  head entry address, data and byte selects.
REQ-012 stb_full_i  in  1  store buffer full.
REQ-013 stb_ack_o  out  1  head entry written to the cache; the store buffer pops its read pointer.
REQ-014 dcache_req_o / dcache_w_en_o  out  1 / 1  cache request and write enable.
REQ-015 dcache_addr_o / dcache_wdata_o / dcache_sel_o  out  ADDR_W / DATA_W / DATA_W/8  cache request payload.
REQ-016 dcache_ack_i / dcache_rdata_i  in  1 / DATA_W  cache completion and read data.

Function
REQ-017 FSM states SHALL be IDLE, LOAD and STORE; the FSM SHALL leave LOAD or STORE for IDLE on the first cycle dcache_ack_i is sampled high.
REQ-018 Arbitration in IDLE SHALL use this priority, first match wins:
- (a) stb_req_i && stb_full_i -> STORE
- (b) stb_req_i && starve_cnt==STARVE_MAX -> STORE
- (c) stb_req_i && lsu_req_i && lsu_addr_i[ADDR_W-1:2]==stb_addr_i[ADDR_W-1:2] -> STORE (load after store to the same word)
- (d) lsu_req_i -> LOAD
- (e) stb_req_i -> STORE
- (f) else stay in IDLE.
REQ-019 On a grant, addr, wdata and sel SHALL be captured into registers; dcache_*_o SHALL be driven from these registers, which SHALL stay stable until ack.
REQ-020 dcache_req_o SHALL be 1 in LOAD and STORE and 0 in IDLE; dcache_w_en_o SHALL be 1 only in STORE.
REQ-021 In LOAD, dcache_wdata_o SHALL be 0 and dcache_sel_o SHALL be all ones.
REQ-022 Latency: a request sampled in IDLE at edge N SHALL produce dcache_req_o=1 from cycle N+1.
REQ-023 Consecutive transactions SHALL be separated by at least one IDLE cycle.
REQ-024 lsu_ack_o SHALL equal dcache_ack_i && state==LOAD, combinationally.
REQ-025 lsu_rdata_o SHALL equal dcache_rdata_i in the lsu_ack_o cycle and 0 otherwise.
REQ-026 stb_ack_o SHALL equal dcache_ack_i && state==STORE, giving exactly one pulse per drained entry.
REQ-027 dcache_ack_i SHALL be ignored in IDLE and SHALL produce no ack output.
REQ-028 starve_cnt SHALL be 3 bits wide (wide enough for STARVE_MAX):
- increments, saturating at STARVE_MAX, on each LOAD grant made while stb_req_i=1
- clears to 0 on every STORE grant
- otherwise holds.
REQ-029 A drop of lsu_req_i or stb_req_i after grant SHALL NOT abort the transaction; the FSM SHALL wait for dcache_ack_i.
REQ-030 If stb_full_i rises during a LOAD, the load SHALL complete first; rule (a) SHALL then apply in the next IDLE cycle.

Reset
REQ-031 With rst_n=0, the following SHALL be forced immediately, without waiting for clk:
- state=IDLE and starve_cnt=0
- captured registers cleared to 0
- all outputs 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no ack pulse; after release the FSM SHALL re-arbitrate from IDLE.

Verification
REQ-033 Single load, addr 0x100, cache ack after 3 cycles with rdata 0xDEADBEEF -> dcache_req_o=1 on cycles 1-3 with w_en=0; lsu_ack_o=1 and lsu_rdata_o=0xDEADBEEF on cycle 3.
REQ-034 lsu_req and stb_req both high, different words, stb not full -> LOAD granted first, then STORE after one IDLE cycle; one stb_ack_o pulse.
REQ-035 Continuous loads with stb_req held high, STARVE_MAX=4 -> 4 LOAD grants, 5th grant STORE, starve_cnt returns to 0.
REQ-036 Load to 0x204 while stb head at 0x206 -> STORE granted first with dcache_sel_o=stb_sel_i, then LOAD.
REQ-037 stb_full_i=1 with lsu_req high -> STORE granted; rst_n pulsed low mid-STORE -> dcache_req_o=0 immediately, no stb_ack_o.
